i_mem_responder: RTL and testbench
==================================

Name: i_mem_responder

Overview:
Instruction-side memory responder at the far end of the shared instruction bus. It receives the single arbitrated fetch request (iREN/iaddr) and answers with the iwait/iload handshake that the bus arbiter fans back out to the requesting core. It sits between the instruction bus arbiter and a synchronous single-port instruction RAM. It inserts a programmable number of wait states so that multi-cycle memory behaviour can be modelled.

Parameters:
LAT, 2, wait-state cycles per fetch; legal range 1..15; values below 1 are treated as 1.
AW, 14, RAM word-address width; the RAM holds 2^AW 32-bit words.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  reset, asynchronous, active-low.
iREN  in  1  fetch request from arbiter; level-held until completion.
iaddr  in  32  byte address of fetch; bits [1:0] ignored.
iinval  in  1  invalidate last-hit buffer (used only with LAST_HIT_EN).
iwait  out  1  1 = not complete; 0 = iload valid this cycle.
iload  out  32  fetched instruction word; valid only when iwait=0.
ram_ren  out  1  RAM read strobe.
ram_addr  out  AW  RAM word address, equal to iaddr[AW+1:2].
ram_rdata  in  32  RAM read data; valid the cycle after ram_ren.

Behaviour:
- Reset values: state=IDLE, cnt=0, addr_q=0, data_q=0, iwait=1, iload=0, ram_ren=0.
- ram_addr is always driven from iaddr[AW+1:2], combinationally.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE, iREN=1: ram_ren=1 this cycle (issue cycle). addr_q<=iaddr, cnt<=LAT, next state WAIT.
- IDLE, iREN=0: ram_ren=0, iwait=1, stay in IDLE.
- WAIT: iwait=1. data_q<=ram_rdata on the first WAIT cycle only (first-cycle flag). cnt decrements each cycle. When cnt reaches 1, next state is ACCESS.
- ACCESS: iwait=0, iload=data_q, for exactly one cycle. Next state is always IDLE.
- Latency: with iREN rising in cycle 0, iwait=0 in cycle LAT+1. Default LAT=2 gives completion in cycle 3.
- Back-to-back fetches: iREN held high after ACCESS is a new fetch, even at the same address. IDLE re-issues in the following cycle. Throughput is one word per LAT+2 cycles.
- iREN deasserted in WAIT: abort. Next state IDLE, no completion pulse, data_q contents discarded.
- Address change in WAIT (iaddr[AW+1:2] != addr_q): restart. ram_ren=1 this cycle, addr_q<=iaddr, cnt<=LAT, first-cycle flag re-armed. The full LAT is recounted from the change.
- iREN deasserted and address changed in the same WAIT cycle: abort takes priority.
- iREN or iaddr changing during ACCESS: ignored. The completion pulse still occurs.
- iwait is 1 in every cycle except ACCESS (and the LAST_HIT_EN hit case). The arbiter relies on this to keep the non-selected core stalled.
- Reset mid-fetch: immediately returns to IDLE with reset values. No completion pulse is emitted.

Optional Feature:
Macro: I_MEM_RESPONDER_LAST_HIT_EN.

Compiled in:
- Single-entry buffer holding hit_valid, hit_addr and hit_data.
- Buffer is loaded in every ACCESS cycle with addr_q and data_q, and hit_valid<=1.
- In IDLE with iREN=1, hit_valid=1, iaddr[AW+1:2]==hit_addr and iinval=0: iwait=0 and iload=hit_data in the same cycle, combinationally. ram_ren=0 and the FSM stays in IDLE.
- iinval=1 clears hit_valid at the next edge. iinval takes priority over a load in the same cycle.
- Reset clears hit_valid.

Compiled out:
- No buffer; iinval is ignored.
- Every fetch takes LAT+1 cycles.

Test Plan:
- Reset then single fetch, LAT=2, iaddr=0x0000_0010, RAM[4]=0x2408_0001 -> ram_ren=1 only in cycle 0; iwait=1 in cycles 0-2; iwait=0 and iload=0x2408_0001 in cycle 3; iwait=1 in cycle 4.
- iREN held high, iaddr=0x10 then 0x14 after completion -> completions in cycles 3 and 7 with RAM[4] then RAM[5]; no extra ram_ren pulses.
- iaddr changes 0x10->0x20 in cycle 1 -> ram_ren pulses in cycles 0 and 1; completion in cycle 4 with RAM[8].
- iREN dropped in cycle 2 -> no iwait=0 cycle; FSM back in IDLE in cycle 3; a new request then completes at the normal LAT+1 latency.
- nRST asserted in cycle 2 of a fetch -> iwait=1, iload=0, ram_ren=0 immediately; no completion after release.
- LAST_HIT_EN: fetch 0x10 completes; refetch 0x10 -> iwait=0 in the same cycle, ram_ren=0; pulse iinval, then refetch 0x10 -> normal 3-cycle latency.

Source files
------------

// File: rtl/i_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : i_mem_responder_if
// Brief    : Fetch handshake (arbiter side) plus RAM port of the responder.
// Revision : 1.0
// ============================================================================
interface i_mem_responder_if #(
    parameter int AW = 14
);
    logic          iREN;
    logic [31:0]   iaddr;
    logic          iinval;
    logic          iwait;
    logic [31:0]   iload;
    logic          ram_ren;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    modport master (
        output iREN, iaddr, iinval, ram_rdata,
        input  iwait, iload, ram_ren, ram_addr
    );

    modport slave (
        input  iREN, iaddr, iinval, ram_rdata,
        output iwait, iload, ram_ren, ram_addr
    );
endinterface
`default_nettype wire

// File: rtl/i_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : i_mem_responder
// Brief    : Instruction-bus memory responder with programmable wait states.
//            Optional single-entry last-hit buffer: I_MEM_RESPONDER_LAST_HIT_EN
// Revision : 1.0
// ============================================================================
module i_mem_responder #(
    parameter int LAT = 2,
    parameter int AW  = 14
) (
    input  wire logic         CLK,
    input  wire logic         nRST,
    i_mem_responder_if.slave  bus
);
    localparam logic [3:0] LAT_C = (LAT < 1)  ? 4'd1  :
                                   (LAT > 15) ? 4'd15 : 4'(LAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          first_q, first_d;

    logic [AW-1:0] word;
    logic          hit;
    logic [31:0]   hit_data;
    logic          ren;
    logic          iwait;
    logic [31:0]   iload;
    logic          unused_bits;

    assign word        = bus.iaddr[AW+1:2];
    assign unused_bits = ^{bus.iaddr[31:AW+2], bus.iaddr[1:0], bus.iinval};

`ifdef I_MEM_RESPONDER_LAST_HIT_EN
    logic          hit_valid_q;
    logic [AW-1:0] hit_addr_q;
    logic [31:0]   hit_data_q;

    // Invalidate wins over a same-cycle refill from ACCESS.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_valid_q <= 1'b0;
            hit_addr_q  <= '0;
            hit_data_q  <= 32'd0;
        end else begin
            if (state_q == ACCESS) begin
                hit_addr_q <= addr_q;
                hit_data_q <= data_q;
            end
            if (bus.iinval)
                hit_valid_q <= 1'b0;
            else if (state_q == ACCESS)
                hit_valid_q <= 1'b1;
        end
    end

    assign hit      = hit_valid_q && (word == hit_addr_q) && !bus.iinval;
    assign hit_data = hit_data_q;
`else
    assign hit      = 1'b0;
    assign hit_data = 32'd0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        first_d = first_q;
        ren     = 1'b0;
        iwait   = 1'b1;
        iload   = 32'd0;
        // Outputs held at their reset values for the whole time reset is low.
        if (nRST) begin
            case (state_q)
                IDLE: begin
                    if (bus.iREN) begin
                        if (hit) begin
                            iwait = 1'b0;
                            iload = hit_data;
                        end else begin
                            ren     = 1'b1;
                            addr_d  = word;
                            cnt_d   = LAT_C;
                            first_d = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.iREN) begin
                        first_d = 1'b0;
                        state_d = IDLE;
                    end else if (word != addr_q) begin
                        ren     = 1'b1;
                        addr_d  = word;
                        cnt_d   = LAT_C;
                        first_d = 1'b1;
                    end else begin
                        if (first_q)
                            data_d = bus.ram_rdata;
                        first_d = 1'b0;
                        cnt_d   = cnt_q - 4'd1;
                        if (cnt_q <= 4'd1)
                            state_d = ACCESS;
                    end
                end
                ACCESS: begin
                    iwait   = 1'b0;
                    iload   = data_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            first_q <= first_d;
        end
    end

    assign bus.iwait    = iwait;
    assign bus.iload    = iload;
    assign bus.ram_ren  = ren;
    assign bus.ram_addr = word;
endmodule
`default_nettype wire

// File: tb/tb_i_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i_mem_responder
// Brief    : Self-checking bench for i_mem_responder (transaction-age model).
// Revision : 1.0
// ============================================================================
module tb_i_mem_responder;
    localparam int LAT   = 2;
    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;
`ifdef I_MEM_RESPONDER_LAST_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [DEPTH];

    i_mem_responder_if #(.AW(AW)) bus ();
    i_mem_responder #(.LAT(LAT), .AW(AW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    always @(posedge CLK)
        if (bus.ram_ren === 1'b1)
            bus.ram_rdata <= mem[bus.ram_addr];

    // Model: an outstanding fetch is described by its word address and its age
    // (cycles since it was issued); it completes at age LAT+1.
    bit          m_busy, n_busy;
    int          m_age, n_age;
    logic [AW-1:0] m_addr, n_addr;
    bit          m_hv, n_hv;
    logic [AW-1:0] m_ha, n_ha;
    logic [31:0] m_hd, n_hd;
    logic        exp_iwait, exp_ren;
    logic [31:0] exp_iload;

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_addr = '0; m_hv = 0; m_ha = '0; m_hd = '0;
        n_busy = 0; n_age = 0; n_addr = '0; n_hv = 0; n_ha = '0; n_hd = '0;
    endtask

    task automatic model_eval();
        logic [AW-1:0] w;
        w = bus.iaddr[AW+1:2];
        exp_iwait = 1'b1; exp_ren = 1'b0; exp_iload = 32'd0;
        n_busy = m_busy; n_age = m_age; n_addr = m_addr;
        n_hv = m_hv; n_ha = m_ha; n_hd = m_hd;
        if (!m_busy) begin
            if (bus.iREN) begin
                if (HIT_EN && m_hv && w == m_ha && !bus.iinval) begin
                    exp_iwait = 1'b0;
                    exp_iload = m_hd;
                end else begin
                    exp_ren = 1'b1; n_busy = 1; n_age = 1; n_addr = w;
                end
            end
        end else if (m_age <= LAT) begin
            if (!bus.iREN) n_busy = 0;
            else if (w != m_addr) begin
                exp_ren = 1'b1; n_age = 1; n_addr = w;
            end else n_age = m_age + 1;
        end else begin
            exp_iwait = 1'b0;
            exp_iload = mem[m_addr];
            n_busy = 0;
            n_hv = 1; n_ha = m_addr; n_hd = mem[m_addr];
        end
        if (bus.iinval) n_hv = 0;
    endtask

    task automatic drive(input logic ren, input logic [31:0] a, input logic inv);
        bus.iREN = ren; bus.iaddr = a; bus.iinval = inv;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        m_busy = n_busy; m_age = n_age; m_addr = n_addr;
        m_hv = n_hv; m_ha = n_ha; m_hd = n_hd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            tick();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.iwait !== 1'b1) begin errors++; $display("FAIL reset_iwait got %b want 1", bus.iwait); end
        checks++; if (bus.iload !== 32'd0) begin errors++; $display("FAIL reset_iload got %h want 0", bus.iload); end
        checks++; if (bus.ram_ren !== 1'b0) begin errors++; $display("FAIL reset_ram_ren got %b want 0", bus.ram_ren); end
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_reset();
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (bus.iwait !== 1'b1) begin errors++; $display("FAIL post_reset_iwait got %b want 1", bus.iwait); end
        tick();
    endtask

    task automatic test_single();
        int rens = 0;
        for (int c = 0; c < 5; c++) begin
            drive(c < 4, 32'h10, 1'b0);
            checks++; if (bus.iwait !== exp_iwait) begin errors++; $display("FAIL single_iwait c%0d got %b want %b", c, bus.iwait, exp_iwait); end
            checks++; if (bus.ram_ren !== exp_ren) begin errors++; $display("FAIL single_ren c%0d got %b want %b", c, bus.ram_ren, exp_ren); end
            if (c == 3) begin
                checks++;
                if (bus.iwait !== 1'b0 || bus.iload !== 32'h2408_0001) begin
                    errors++; $display("FAIL single_done got iwait=%b iload=%h want 0/24080001", bus.iwait, bus.iload);
                end
            end
            if (bus.ram_ren === 1'b1) rens++;
            tick();
        end
        checks++; if (rens != 1) begin errors++; $display("FAIL single_ren_count got %0d want 1", rens); end
    endtask

    task automatic test_back_to_back();
        int rens = 0;
        int done[$];
        logic [31:0] dat[$];
        for (int c = 0; c < 9; c++) begin
            drive(c < 8, (c < 4) ? 32'h10 : 32'h14, 1'b0);
            checks++; if (bus.iwait !== exp_iwait) begin errors++; $display("FAIL b2b_iwait c%0d got %b want %b", c, bus.iwait, exp_iwait); end
            if (bus.iwait === 1'b0) begin done.push_back(c); dat.push_back(bus.iload); end
            if (bus.ram_ren === 1'b1) rens++;
            tick();
        end
        checks++;
        if (done.size() != 2 || done[0] != 3 || done[1] != 7) begin
            errors++; $display("FAIL b2b_cycles got %0d completions want cycles 3,7", done.size());
        end else begin
            checks++; if (dat[0] !== mem[4] || dat[1] !== mem[5]) begin errors++; $display("FAIL b2b_data got %h,%h want %h,%h", dat[0], dat[1], mem[4], mem[5]); end
        end
        checks++; if (rens != 2) begin errors++; $display("FAIL b2b_ren_count got %0d want 2", rens); end
    endtask

    task automatic test_addr_change();
        logic [5:0] renmask = '0;
        for (int c = 0; c < 6; c++) begin
            drive(c < 5, (c == 0) ? 32'h10 : 32'h20, 1'b0);
            checks++; if (bus.iwait !== exp_iwait) begin errors++; $display("FAIL chg_iwait c%0d got %b want %b", c, bus.iwait, exp_iwait); end
            renmask[c] = (bus.ram_ren === 1'b1);
            if (c == 4) begin
                checks++;
                if (bus.iwait !== 1'b0 || bus.iload !== mem[8]) begin
                    errors++; $display("FAIL chg_done got iwait=%b iload=%h want 0/%h", bus.iwait, bus.iload, mem[8]);
                end
            end
            tick();
        end
        checks++; if (renmask !== 6'b000011) begin errors++; $display("FAIL chg_ren_mask got %b want 000011", renmask); end
    endtask

    task automatic test_abort();
        logic [8:0] donemask = '0;
        for (int c = 0; c < 9; c++) begin
            drive((c < 2) || (c >= 4 && c < 8), 32'h30, 1'b0);
            checks++; if (bus.iwait !== exp_iwait) begin errors++; $display("FAIL abort_iwait c%0d got %b want %b", c, bus.iwait, exp_iwait); end
            if (!exp_iwait) begin
                checks++; if (bus.iload !== exp_iload) begin errors++; $display("FAIL abort_iload c%0d got %h want %h", c, bus.iload, exp_iload); end
            end
            donemask[c] = (bus.iwait === 1'b0);
            tick();
        end
        checks++; if (donemask !== 9'b0_1000_0000) begin errors++; $display("FAIL abort_done_mask got %b want 010000000", donemask); end
    endtask

    task automatic test_access_ignore();
        for (int c = 0; c < 5; c++) begin
            drive(c < 3, (c < 3) ? 32'h10 : 32'h44, 1'b0);
            checks++; if (bus.iwait !== exp_iwait) begin errors++; $display("FAIL acc_iwait c%0d got %b want %b", c, bus.iwait, exp_iwait); end
            if (c == 3) begin
                checks++;
                if (bus.iwait !== 1'b0 || bus.iload !== mem[4]) begin
                    errors++; $display("FAIL acc_done got iwait=%b iload=%h want 0/%h", bus.iwait, bus.iload, mem[4]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midfetch();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 32'h40, 1'b0);
            tick();
        end
        drive(1'b1, 32'h40, 1'b0);
        nRST = 1'b0;
        #1;
        checks++; if (bus.iwait !== 1'b1) begin errors++; $display("FAIL rstmid_iwait got %b want 1", bus.iwait); end
        checks++; if (bus.iload !== 32'd0) begin errors++; $display("FAIL rstmid_iload got %h want 0", bus.iload); end
        checks++; if (bus.ram_ren !== 1'b0) begin errors++; $display("FAIL rstmid_ren got %b want 0", bus.ram_ren); end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_reset();
        for (int c = 0; c < LAT + 3; c++) begin
            drive(1'b0, 32'h40, 1'b0);
            checks++; if (bus.iwait !== 1'b1) begin errors++; $display("FAIL rstmid_nodone c%0d got %b want 1", c, bus.iwait); end
            tick();
        end
    endtask

`ifdef I_MEM_RESPONDER_LAST_HIT_EN
    task automatic test_last_hit();
        for (int c = 0; c < 11; c++) begin
            drive((c < 5) || (c >= 6 && c < 10), 32'h10, c == 5);
            checks++; if (bus.iwait !== exp_iwait) begin errors++; $display("FAIL hit_iwait c%0d got %b want %b", c, bus.iwait, exp_iwait); end
            checks++; if (bus.ram_ren !== exp_ren) begin errors++; $display("FAIL hit_ren c%0d got %b want %b", c, bus.ram_ren, exp_ren); end
            if (c == 4 || c == 9) begin
                checks++;
                if (bus.iwait !== 1'b0 || bus.iload !== mem[4]) begin
                    errors++; $display("FAIL hit_done c%0d got iwait=%b iload=%h want 0/%h", c, bus.iwait, bus.iload, mem[4]);
                end
            end
            tick();
        end
    endtask
`else
    task automatic test_refetch();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 32'h10, 1'b0);
            if (c == 4) begin
                checks++;
                if (bus.iwait !== 1'b1 || bus.ram_ren !== 1'b1) begin
                    errors++; $display("FAIL refetch got iwait=%b ren=%b want 1/1", bus.iwait, bus.ram_ren);
                end
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        logic [AW-1:0] w;
        logic [31:0]   r;
        w = 14'd4;
        for (int c = 0; c < 600; c++) begin
            r = $urandom();
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 4))
                    0: w = 14'd4;
                    1: w = 14'd5;
                    2: w = 14'd8;
                    3: w = 14'd12;
                    default: w = AW'($urandom());
                endcase
            end
            drive($urandom_range(0, 7) != 0, {r[31:AW+2], w, r[1:0]}, $urandom_range(0, 9) == 0);
            checks++; if (bus.iwait !== exp_iwait) begin errors++; $display("FAIL rnd_iwait c%0d got %b want %b", c, bus.iwait, exp_iwait); end
            checks++; if (bus.ram_ren !== exp_ren) begin errors++; $display("FAIL rnd_ren c%0d got %b want %b", c, bus.ram_ren, exp_ren); end
            checks++; if (bus.ram_addr !== w) begin errors++; $display("FAIL rnd_ram_addr c%0d got %h want %h", c, bus.ram_addr, w); end
            if (!exp_iwait) begin
                checks++; if (bus.iload !== exp_iload) begin errors++; $display("FAIL rnd_iload c%0d got %h want %h", c, bus.iload, exp_iload); end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        mem[4] = 32'h2408_0001;
        nRST = 1'b0;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h10;
        bus.iinval = 1'b0;
        bus.ram_rdata = 32'd0;
        model_reset();

        test_reset();
        test_single();
        idle(2);
        test_back_to_back();
        idle(2);
        test_addr_change();
        idle(2);
        test_abort();
        idle(2);
        test_access_ignore();
        idle(2);
`ifdef I_MEM_RESPONDER_LAST_HIT_EN
        test_last_hit();
`else
        test_refetch();
`endif
        idle(4);
        test_reset_midfetch();
        idle(2);
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
